// File: rtl/axi_mem_tester_pkg.sv
// Shared types and constants for the AXI DDR memory tester.
// Also holds the LFSR step used by the pattern generators.
package axi_mem_tester_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWa,
        StWd,
        StWb,
        StRa,
        StRd,
        StEnd,
        StDone
    } state_e;

    localparam logic [1:0] MODE_ADDR  = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;
    localparam logic [1:0] MODE_INV   = 2'd3;

    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [3:0]  AXI_CACHE      = 4'b0011;
    localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;
    localparam logic [31:0] CONST_PATTERN  = 32'hcafe_beef;

    // Right-shifting Galois step: the bit shifted out selects the tap mask.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/axi_mem_tester_pattern.sv
// Test-data generator. The LFSR state is reloaded at each phase start and
// stepped once per accepted beat; the other modes are pure functions of the address.
module mem_test_pattern
    import axi_mem_tester_pkg::*;
#(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       seed,
    input  logic              load,
    input  logic              step,
    output logic [DATA_W-1:0] data
);

    logic [31:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed ^ 32'h1;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 32'h0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        data = '0;
        case (mode)
            MODE_ADDR:  data = DATA_W'(addr);
            MODE_LFSR:  data = {(DATA_W/32){lfsr_q}};
            MODE_CONST: data = {(DATA_W/32){CONST_PATTERN}};
            MODE_INV:   data = ~DATA_W'(addr);
            default:    data = '0;
        endcase
    end

endmodule

// File: rtl/axi_mem_tester.sv
// AXI4 master that writes a pattern over a DDR region in INCR bursts, reads it
// back and counts mismatches. One burst outstanding at a time; optional looping.
module axi_mem_tester
    import axi_mem_tester_pkg::*;
#(
    parameter int unsigned ADDR_W    = 28,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned NUM_WORDS = 1024,
    parameter int unsigned BURST_LEN = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic                loop,
    input  logic                stop,
    output logic [ID_W-1:0]     m_axi_awid,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awlock,
    output logic [3:0]          m_axi_awcache,
    output logic [2:0]          m_axi_awprot,
    output logic [3:0]          m_axi_awqos,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic                m_axi_bready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic [ID_W-1:0]     m_axi_arid,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic                m_axi_arlock,
    output logic [3:0]          m_axi_arcache,
    output logic [2:0]          m_axi_arprot,
    output logic [3:0]          m_axi_arqos,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    output logic                m_axi_rready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    input  logic                m_axi_rvalid,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                resp_err,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [15:0]         pass_count
);

    localparam int unsigned BYTES       = DATA_W / 8;
    localparam int unsigned BURST_BYTES = BURST_LEN * BYTES;
    localparam int unsigned NUM_BURSTS  = NUM_WORDS / BURST_LEN;
    localparam int unsigned BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned BIDX_W      = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [BIDX_W-1:0] LAST_BURST = BIDX_W'(NUM_BURSTS - 1);
    localparam logic [2:0]        AXI_SIZE   = 3'($clog2(BYTES));
    localparam logic [7:0]        AXI_LEN    = 8'(BURST_LEN - 1);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [BIDX_W-1:0]   burst_q, burst_d;
    logic [1:0]          mode_q, mode_d;
    logic [31:0]         seed_q, seed_d;
    logic                stop_q, stop_d;
    logic [15:0]         err_count_q, err_count_d;
    logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;
    logic                resp_err_q, resp_err_d;
    logic                done_q, done_d;
    logic [15:0]         pass_count_q, pass_count_d;

    logic [ADDR_W-1:0]   burst_addr, beat_addr;
    logic [DATA_W-1:0]   wr_data, rd_data;
    logic                wr_load, wr_step, rd_load, rd_step;
    logic                last_beat, last_burst;

    assign burst_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(burst_q) * ADDR_W'(BURST_BYTES);
    assign beat_addr  = burst_addr + ADDR_W'(beat_q) * ADDR_W'(BYTES);
    assign last_beat  = (beat_q == LAST_BEAT);
    assign last_burst = (burst_q == LAST_BURST);
    assign busy       = (state_q != StIdle) && (state_q != StDone);

    always_comb begin
        state_d          = state_q;
        beat_d           = beat_q;
        burst_d          = burst_q;
        mode_d           = mode_q;
        seed_d           = seed_q;
        stop_d           = stop_q | (stop & busy);
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        resp_err_d       = resp_err_q;
        done_d           = done_q;
        pass_count_d     = pass_count_q;
        wr_load          = 1'b0;
        wr_step          = 1'b0;
        rd_load          = 1'b0;
        rd_step          = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d          = StWa;
                    beat_d           = '0;
                    burst_d          = '0;
                    mode_d           = mode;
                    seed_d           = 32'h0;
                    stop_d           = 1'b0;
                    err_count_d      = 16'h0;
                    first_err_addr_d = '0;
                    resp_err_d       = 1'b0;
                    done_d           = 1'b0;
                    wr_load          = 1'b1;
                end
            end
            StWa: begin
                if (m_axi_awready) state_d = StWd;
            end
            StWd: begin
                if (m_axi_wready) begin
                    wr_step = 1'b1;
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = StWb;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StWb: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != AXI_RESP_OKAY) resp_err_d = 1'b1;
                    if (stop_d) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else if (last_burst) begin
                        burst_d = '0;
                        state_d = StRa;
                        rd_load = 1'b1;
                    end else begin
                        burst_d = burst_q + 1'b1;
                        state_d = StWa;
                    end
                end
            end
            StRa: begin
                if (m_axi_arready) state_d = StRd;
            end
            StRd: begin
                if (m_axi_rvalid) begin
                    rd_step = 1'b1;
                    if (m_axi_rresp != AXI_RESP_OKAY) resp_err_d = 1'b1;
                    // Slave's rlast is only policed; the burst ends on our own beat count.
                    if (m_axi_rlast != last_beat) resp_err_d = 1'b1;
                    if (m_axi_rdata != rd_data) begin
                        if (err_count_q == 16'h0) first_err_addr_d = beat_addr;
                        if (err_count_q != 16'hffff) err_count_d = err_count_q + 16'd1;
                    end
                    if (last_beat) begin
                        beat_d = '0;
                        if (stop_d) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else if (last_burst) begin
                            burst_d = '0;
                            state_d = StEnd;
                        end else begin
                            burst_d = burst_q + 1'b1;
                            state_d = StRa;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StEnd: begin
                pass_count_d = pass_count_q + 16'd1;
                if (loop) begin
                    seed_d  = seed_q + 32'd1;
                    state_d = StWa;
                    wr_load = 1'b1;
                end else begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            beat_q           <= '0;
            burst_q          <= '0;
            mode_q           <= 2'd0;
            seed_q           <= 32'h0;
            stop_q           <= 1'b0;
            err_count_q      <= 16'h0;
            first_err_addr_q <= '0;
            resp_err_q       <= 1'b0;
            done_q           <= 1'b0;
            pass_count_q     <= 16'h0;
        end else begin
            state_q          <= state_d;
            beat_q           <= beat_d;
            burst_q          <= burst_d;
            mode_q           <= mode_d;
            seed_q           <= seed_d;
            stop_q           <= stop_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            resp_err_q       <= resp_err_d;
            done_q           <= done_d;
            pass_count_q     <= pass_count_d;
        end
    end

    // Both generators see the same beat address; phases never overlap.
    mem_test_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_pattern (
        .clk  (clk),
        .rst  (rst),
        .mode (mode_q),
        .addr (beat_addr),
        .seed (seed_d),
        .load (wr_load),
        .step (wr_step),
        .data (wr_data)
    );

    mem_test_pattern #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rd_pattern (
        .clk  (clk),
        .rst  (rst),
        .mode (mode_q),
        .addr (beat_addr),
        .seed (seed_d),
        .load (rd_load),
        .step (rd_step),
        .data (rd_data)
    );

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = burst_addr;
    assign m_axi_awlen   = AXI_LEN;
    assign m_axi_awsize  = AXI_SIZE;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = AXI_CACHE;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'h0;
    assign m_axi_awvalid = (state_q == StWa);

    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = (state_q == StWd);
    assign m_axi_wlast   = (state_q == StWd) && last_beat;
    assign m_axi_bready  = (state_q == StWb);

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = burst_addr;
    assign m_axi_arlen   = AXI_LEN;
    assign m_axi_arsize  = AXI_SIZE;
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = AXI_CACHE;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'h0;
    assign m_axi_arvalid = (state_q == StRa);
    assign m_axi_rready  = (state_q == StRd);

    assign done           = done_q;
    assign pass           = done_q && (err_count_q == 16'h0) && !resp_err_q;
    assign resp_err       = resp_err_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign pass_count     = pass_count_q;

endmodule
